// File: rtl/cache_fill_unit.sv
// Line-fill engine between the L1 I/D caches and the memory bus: one outstanding
// read at a time, multi-beat response assembled into a full line, data side first.
module cache_fill_unit #(
  parameter int                       BUS_DATA_WIDTH = 64,
  parameter int                       BUS_TAG_WIDTH  = 13,
  parameter int                       ADDRESS_SIZE   = 64,
  parameter int                       LINE_BYTES     = 64,
  parameter logic [BUS_TAG_WIDTH-1:0] READ_TAG       = 13'h0001
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      d_fill_req,
  input  logic [ADDRESS_SIZE-1:0]   d_fill_addr,
  input  logic                      i_fill_req,
  input  logic [ADDRESS_SIZE-1:0]   i_fill_addr,
  output logic                      fill_busy,
  output logic                      d_fill_valid,
  output logic                      i_fill_valid,
  output logic [LINE_BYTES*8-1:0]   fill_line,
  output logic [ADDRESS_SIZE-1:0]   fill_addr,
  output logic                      bus_reqcyc,
  input  logic                      bus_reqack,
  output logic [BUS_DATA_WIDTH-1:0] bus_req,
  output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  input  logic                      bus_respcyc,
  output logic                      bus_respack,
  input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag
);

  localparam int BEATS = (LINE_BYTES * 8) / BUS_DATA_WIDTH;
  localparam int CNT_W = $clog2(BEATS);
  localparam int OFF_W = $clog2(LINE_BYTES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                                 state_r;
  state_t                                 next_state_s;
  logic [CNT_W-1:0]                       beat_cnt_r;
  logic [BEATS-1:0][BUS_DATA_WIDTH-1:0]   line_buf_r;
  logic [BEATS-1:0][BUS_DATA_WIDTH-1:0]   line_next_s;
  logic [ADDRESS_SIZE-1:0]                addr_r;
  logic                                   owner_d_r;
  logic                                   fill_busy_r;
  logic                                   d_valid_r;
  logic                                   i_valid_r;
  logic [LINE_BYTES*8-1:0]                fill_line_r;
  logic [ADDRESS_SIZE-1:0]                fill_addr_r;
  logic                                   reqcyc_r;
  logic [BUS_DATA_WIDTH-1:0]              bus_req_r;
  logic [BUS_TAG_WIDTH-1:0]               reqtag_r;
  logic                                   capture_s;
  logic                                   cap_d_s;
  logic [ADDRESS_SIZE-1:0]                cap_addr_s;
  logic                                   beat_s;
  logic                                   last_beat_s;
  logic                                   unused_s;

  // Response tag and in-line offset bits carry no information for the fill.
  assign unused_s = ^{bus_resptag, d_fill_addr[OFF_W-1:0], i_fill_addr[OFF_W-1:0]};

  // Every beat is accepted: in RESP it is stored, in any other state it is dropped.
  assign bus_respack  = bus_respcyc;
  assign fill_busy    = fill_busy_r;
  assign d_fill_valid = d_valid_r;
  assign i_fill_valid = i_valid_r;
  assign fill_line    = fill_line_r;
  assign fill_addr    = fill_addr_r;
  assign bus_reqcyc   = reqcyc_r;
  assign bus_req      = bus_req_r;
  assign bus_reqtag   = reqtag_r;

  // Next-state decode, request arbitration and beat strobes.
  always_comb begin
    next_state_s = state_r;
    capture_s    = 1'b0;
    cap_d_s      = 1'b0;
    cap_addr_s   = {ADDRESS_SIZE{1'b0}};
    beat_s       = 1'b0;
    last_beat_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (d_fill_req) begin
          capture_s    = 1'b1;
          cap_d_s      = 1'b1;
          cap_addr_s   = {d_fill_addr[ADDRESS_SIZE-1:OFF_W], {OFF_W{1'b0}}};
          next_state_s = REQ;
        end else if (i_fill_req) begin
          capture_s    = 1'b1;
          cap_d_s      = 1'b0;
          cap_addr_s   = {i_fill_addr[ADDRESS_SIZE-1:OFF_W], {OFF_W{1'b0}}};
          next_state_s = REQ;
        end else begin
          next_state_s = IDLE;
        end
      end
      REQ: begin
        if (bus_reqack) begin
          next_state_s = RESP;
        end else begin
          next_state_s = REQ;
        end
      end
      RESP: begin
        beat_s = bus_respcyc;
        if (bus_respcyc && (beat_cnt_r == CNT_W'(BEATS - 1))) begin
          last_beat_s  = 1'b1;
          next_state_s = DONE;
        end else begin
          next_state_s = RESP;
        end
      end
      DONE: begin
        next_state_s = IDLE;
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Line buffer with the current beat merged into its slot.
  always_comb begin
    line_next_s             = line_buf_r;
    line_next_s[beat_cnt_r] = bus_resp;
  end

  // State, bus request channel, beat collection and the delivered line.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      beat_cnt_r  <= {CNT_W{1'b0}};
      line_buf_r  <= {(BEATS*BUS_DATA_WIDTH){1'b0}};
      addr_r      <= {ADDRESS_SIZE{1'b0}};
      owner_d_r   <= 1'b0;
      fill_busy_r <= 1'b0;
      d_valid_r   <= 1'b0;
      i_valid_r   <= 1'b0;
      fill_line_r <= {(LINE_BYTES*8){1'b0}};
      fill_addr_r <= {ADDRESS_SIZE{1'b0}};
      reqcyc_r    <= 1'b0;
      bus_req_r   <= {BUS_DATA_WIDTH{1'b0}};
      reqtag_r    <= {BUS_TAG_WIDTH{1'b0}};
    end else begin
      state_r     <= next_state_s;
      fill_busy_r <= (next_state_s != IDLE);
      d_valid_r   <= last_beat_s & owner_d_r;
      i_valid_r   <= last_beat_s & ~owner_d_r;
      if (capture_s) begin
        addr_r    <= cap_addr_s;
        owner_d_r <= cap_d_s;
        reqcyc_r  <= 1'b1;
        bus_req_r <= BUS_DATA_WIDTH'(cap_addr_s);
        reqtag_r  <= READ_TAG;
      end else if ((state_r == REQ) && bus_reqack) begin
        reqcyc_r <= 1'b0;
        reqtag_r <= {BUS_TAG_WIDTH{1'b0}};
      end
      if (beat_s) begin
        line_buf_r <= line_next_s;
        beat_cnt_r <= last_beat_s ? {CNT_W{1'b0}} : (beat_cnt_r + CNT_W'(1));
      end
      // The visible line only changes when a complete line has arrived.
      if (last_beat_s) begin
        fill_line_r <= line_next_s;
        fill_addr_r <= addr_r;
      end
    end
  end

endmodule
